// File: rtl/urex6_pkg.sv
// Shared sprite-fetch/palette definitions: sprite geometry defaults, derived widths,
// the palette index type and the power-up contents of the sprite ROM.
package urex6_pkg;

    localparam int SPR_W_DEF       = 32;
    localparam int SPR_H_DEF       = 32;
    localparam int FRAMES_DEF      = 2;
    localparam int FRAME_TICKS_DEF = 8;
    localparam int TRANSPARENT_IDX = 0;

    localparam int FRAME_W = (FRAMES_DEF > 1) ? $clog2(FRAMES_DEF) : 1;
    localparam int ADDR_W  = $clog2(FRAMES_DEF * SPR_W_DEF * SPR_H_DEF);

    typedef logic [3:0] pal_idx_t;

    // Built-in artwork when no hex image is supplied: index = (rx - ry + 12 + 5*frame) mod 16,
    // which yields a diagonal of transparent pixels and differs between frames.
    function automatic pal_idx_t rom_default_word(input int unsigned addr,
                                                  input int unsigned spr_w,
                                                  input int unsigned spr_h);
        int unsigned rx;
        int unsigned ry;
        int unsigned fr;
        int          v;
        rx = addr % spr_w;
        ry = (addr / spr_w) % spr_h;
        fr = addr / (spr_w * spr_h);
        v  = int'(rx) - int'(ry) + 12 + 5 * int'(fr);
        return pal_idx_t'(v);
    endfunction

endpackage

// File: rtl/urex6_sprite_rom.sv
// Synchronous single-port sprite ROM, one-cycle read latency. Contents are the
// package artwork, built into the memory array at elaboration time.
module urex6_sprite_rom
  import urex6_pkg::*;
#(
  parameter int SPR_W     = SPR_W_DEF,
  parameter int SPR_H     = SPR_H_DEF,
  parameter int FRAMES    = FRAMES_DEF,
  parameter int AW        = ADDR_W,
  parameter     INIT_FILE = ""
) (
  input  logic          Clk,
  input  logic [AW-1:0] addr,
  output pal_idx_t      q
);

  localparam int DEPTH = FRAMES * SPR_W * SPR_H;

  pal_idx_t mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = rom_default_word(i, SPR_W, SPR_H);
    end
  end

  always_ff @(posedge Clk) begin
    q <= mem[addr];
  end

endmodule

// File: rtl/urex6_sprite_fetch.sv
// Per-pixel sprite fetch ahead of the urex6 palette lookup: bounds test, ROM read,
// vsync-latched position and animation. Optional horizontal flip: UREX6_MIRROR_EN.
module urex6_sprite_fetch
    import urex6_pkg::*;
#(
    parameter int SPR_W       = SPR_W_DEF,
    parameter int SPR_H       = SPR_H_DEF,
    parameter int FRAMES      = FRAMES_DEF,
    parameter int FRAME_TICKS = FRAME_TICKS_DEF,
    parameter int TRANSP_IDX  = TRANSPARENT_IDX,
    parameter     INIT_FILE   = ""
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      vs,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic [9:0]                sprite_x,
    input  logic [9:0]                sprite_y,
    input  logic                      sprite_en,
    input  logic                      anim_en,
`ifdef UREX6_MIRROR_EN
    input  logic                      mirror,
`endif
    output pal_idx_t                  pix_index,
    output logic                      pix_opaque,
    output logic [$clog2(FRAMES)-1:0] frame_num
);

    localparam int FW = $clog2(FRAMES);
    localparam int AW = $clog2(FRAMES * SPR_W * SPR_H);
    localparam int XB = $clog2(SPR_W);
    localparam int YB = $clog2(SPR_H);
    localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    localparam logic signed [10:0] SPR_W_S = 11'(SPR_W);
    localparam logic signed [10:0] SPR_H_S = 11'(SPR_H);

    logic          vs_prev;
    logic          vs_evt;
    logic [9:0]    sx;
    logic [9:0]    sy;
    logic          sen;
    logic [TW-1:0] tick;
`ifdef UREX6_MIRROR_EN
    logic          smir;
`endif

    // vs_prev resets high so an idle-high vsync right after reset is not an event
    assign vs_evt = vs & ~vs_prev;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_prev   <= 1'b1;
            sx        <= '0;
            sy        <= '0;
            sen       <= 1'b0;
            tick      <= '0;
            frame_num <= '0;
`ifdef UREX6_MIRROR_EN
            smir      <= 1'b0;
`endif
        end else begin
            vs_prev <= vs;
            if (vs_evt) begin
                sx  <= sprite_x;
                sy  <= sprite_y;
                sen <= sprite_en;
`ifdef UREX6_MIRROR_EN
                smir <= mirror;
`endif
                if (anim_en) begin
                    if (tick == TW'(FRAME_TICKS - 1)) begin
                        tick      <= '0;
                        frame_num <= (frame_num == FW'(FRAMES - 1)) ? '0 : frame_num + 1'b1;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
            end
        end
    end

    // ---- stage 0: sprite-relative coordinates, bounds test, ROM address ----
    logic signed [10:0] rx;
    logic signed [10:0] ry;
    logic               inb_p0;
    logic [XB-1:0]      col_p0;
    logic [AW-1:0]      addr_p0;

    always_comb begin
        rx     = $signed({1'b0, DrawX}) - $signed({1'b0, sx});
        ry     = $signed({1'b0, DrawY}) - $signed({1'b0, sy});
        inb_p0 = sen && (rx >= 11'sd0) && (rx < SPR_W_S) && (ry >= 11'sd0) && (ry < SPR_H_S);
`ifdef UREX6_MIRROR_EN
        col_p0 = smir ? (XB'(SPR_W - 1) - rx[XB-1:0]) : rx[XB-1:0];
`else
        col_p0 = rx[XB-1:0];
`endif
        addr_p0 = AW'(frame_num) * AW'(SPR_W * SPR_H)
                + AW'(ry[YB-1:0]) * AW'(SPR_W)
                + AW'(col_p0);
    end

    // ---- stage 1: ROM address register (inside the ROM) and valid ----
    pal_idx_t rom_q_p1;
    logic     vld_p1;

    urex6_sprite_rom #(
        .SPR_W     (SPR_W),
        .SPR_H     (SPR_H),
        .FRAMES    (FRAMES),
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .Clk  (Clk),
        .addr (addr_p0),
        .q    (rom_q_p1)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= inb_p0;
        end
    end

    // ---- stage 2: registered outputs; ROM data is gated by valid so nothing stale escapes ----
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_index  <= '0;
            pix_opaque <= 1'b0;
        end else begin
            pix_index  <= vld_p1 ? rom_q_p1 : '0;
            pix_opaque <= vld_p1 && (rom_q_p1 != 4'(TRANSP_IDX));
        end
    end

endmodule

// File: tb/tb_urex6_sprite_fetch.sv
// Scoreboard bench for urex6_sprite_fetch using the built-in ROM artwork
// (index = (rx - ry + 12 + 5*frame) mod 16).
module tb_urex6_sprite_fetch;
    import urex6_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       vs;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [9:0] sprite_x;
    logic [9:0] sprite_y;
    logic       sprite_en;
    logic       anim_en;
    logic       mirror;
    pal_idx_t   pix_index;
    logic       pix_opaque;
    logic [0:0] frame_num;

    always #5 Clk = ~Clk;

    urex6_sprite_fetch dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .vs         (vs),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .sprite_en  (sprite_en),
        .anim_en    (anim_en),
`ifdef UREX6_MIRROR_EN
        .mirror     (mirror),
`endif
        .pix_index  (pix_index),
        .pix_opaque (pix_opaque),
        .frame_num  (frame_num)
    );

    typedef struct {
        int          due;
        logic [3:0]  idx;
        logic        opq;
        string       name;
    } pix_exp_t;

    typedef struct {
        int          due;
        logic        fr;
        string       name;
    } frm_exp_t;

    pix_exp_t pq[$];
    frm_exp_t fq[$];
    int cyc    = 0;
    int ntests = 0;
    int nfail  = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: pops every expectation whose output cycle has arrived
    always @(negedge Clk) begin
        pix_exp_t pe;
        frm_exp_t fe;
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            pe = pq.pop_front();
            ntests++;
            if (pe.due != cyc) begin
                nfail++;
                $display("FAIL %s: check missed, due cycle %0d, now %0d", pe.name, pe.due, cyc);
            end else if (pix_index !== pe.idx || pix_opaque !== pe.opq) begin
                nfail++;
                $display("FAIL %s: got index=%0h opaque=%b, expected index=%0h opaque=%b",
                         pe.name, pix_index, pix_opaque, pe.idx, pe.opq);
            end
        end
        while (fq.size() > 0 && fq[0].due <= cyc) begin
            fe = fq.pop_front();
            ntests++;
            if (frame_num !== fe.fr) begin
                nfail++;
                $display("FAIL %s: got frame_num=%b, expected %b", fe.name, frame_num, fe.fr);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drive one pixel; its registered output appears two edges later
    task automatic pix(input int x, input int y, input logic [3:0] ei, input logic eo, input string nm);
        DrawX = 10'(x);
        DrawY = 10'(y);
        pq.push_back('{cyc + 2, ei, eo, nm});
        tick();
    endtask

    task automatic chk_frame(input logic fr, input string nm);
        fq.push_back('{cyc, fr, nm});
    endtask

    // Low pulse on vs; the rising edge is the frame event
    task automatic vsync();
        DrawX = 10'd1000;
        DrawY = 10'd500;
        vs = 1'b0;
        tick();
        tick();
        vs = 1'b1;
        tick();
    endtask

    initial begin
        Reset = 1'b1; vs = 1'b1; DrawX = '0; DrawY = '0;
        sprite_x = '0; sprite_y = '0; sprite_en = 1'b0; anim_en = 1'b0; mirror = 1'b0;
        repeat (3) tick();
        chk_frame(1'b0, "reset_frame");
        pix(0, 0, 4'h0, 1'b0, "reset_pix");
        tick();
        Reset = 1'b0;

        // Position is ignored until a vsync event latches it
        sprite_x = 10'd100; sprite_y = 10'd50; sprite_en = 1'b1;
        tick();
        pix(105, 60, 4'h0, 1'b0, "pre_latch");
        vsync();

        // Bounds and data at shadow (100,50), frame 0
        pix( 99, 60, 4'h0, 1'b0, "left_out");
        pix(100, 60, 4'h2, 1'b1, "left_edge");
        pix(105, 60, 4'h7, 1'b1, "rx5_ry10");
        pix(130, 60, 4'h0, 1'b0, "transparent_rx30");
        pix(131, 60, 4'h1, 1'b1, "right_edge");
        pix(132, 60, 4'h0, 1'b0, "right_out");
        pix(104, 50, 4'h0, 1'b0, "transparent_top");
        pix(100, 50, 4'hc, 1'b1, "top_left");
        pix(105, 49, 4'h0, 1'b0, "above_out");
        pix(105, 81, 4'h2, 1'b1, "bottom_row");
        pix(105, 82, 4'h0, 1'b0, "below_out");
        chk_frame(1'b0, "frame_static");

        // Position change mid-frame waits for the next event
        sprite_x = 10'd200;
        pix(105, 60, 4'h7, 1'b1, "latch_hold_old");
        pix(205, 60, 4'h0, 1'b0, "latch_hold_new");
        vsync();
        pix(205, 60, 4'h7, 1'b1, "latch_follow_new");
        pix(105, 60, 4'h0, 1'b0, "latch_drop_old");

        // Right-edge clipping with no wrap to the next line
        sprite_x = 10'd620;
        vsync();
        pix(620, 60, 4'h2, 1'b1, "clip_first");
        pix(639, 60, 4'h5, 1'b1, "clip_last");
        pix(  0, 61, 4'h0, 1'b0, "clip_nowrap0");
        pix( 11, 61, 4'h0, 1'b0, "clip_nowrap11");
        pix(625, 61, 4'h6, 1'b1, "clip_row61");

        // sprite_x=1023 puts every on-screen column left of the sprite
        sprite_x = 10'd1023;
        vsync();
        pix( 0, 60, 4'h0, 1'b0, "x1023_col0");
        pix(31, 60, 4'h0, 1'b0, "x1023_col31");

        // Animation: 8 events per frame, two frames
        sprite_x = 10'd200;
        anim_en = 1'b1;
        repeat (7) vsync();
        chk_frame(1'b0, "anim_after7");
        vsync();
        chk_frame(1'b1, "anim_after8");
        pix(205, 60, 4'hc, 1'b1, "frame1_rx5");
        pix(230, 60, 4'h5, 1'b1, "frame1_rx30");
        repeat (7) vsync();
        chk_frame(1'b1, "anim_after15");
        vsync();
        chk_frame(1'b0, "anim_after16");
        pix(205, 60, 4'h7, 1'b1, "frame0_again");
        repeat (8) vsync();
        chk_frame(1'b1, "anim_after24");
        anim_en = 1'b0;
        repeat (20) vsync();
        chk_frame(1'b1, "anim_hold20");

        // Reset mid-line with the sprite on screen in frame 1
        pix(205, 60, 4'h0, 1'b0, "rst_mid_inflight");
        Reset = 1'b1;
        pix(206, 60, 4'h0, 1'b0, "rst_mid_next");
        chk_frame(1'b0, "rst_mid_frame");
        Reset = 1'b0;
        pix(207, 60, 4'h0, 1'b0, "rst_post1");
        pix(208, 60, 4'h0, 1'b0, "rst_post2");
        pix(205, 60, 4'h0, 1'b0, "rst_post_disabled");
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
